// File: rtl/bin_to_bcd_serial_pkg.sv
// Shared types for the serial double-dabble binary-to-BCD converter:
// FSM state encoding and a helper that sizes the BCD output for a binary width.
package bin_to_bcd_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Smallest digit count whose decimal range covers 2^width - 1.
    function automatic int unsigned bcd_digits(input int unsigned width);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << width) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_column.sv
// Combinational double-dabble correction: every BCD nibble >= 5 gets +3,
// with no carry between nibbles.
module bcd_add3_column #(
    parameter int unsigned digits = 3
) (
    input  logic [4*digits-1:0] value,
    output logic [4*digits-1:0] adjusted
);

    always_comb begin
        adjusted = value;
        for (int unsigned i = 0; i < digits; i++) begin
            if (value[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = value[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble converter, one binary bit per clock, start/busy/done handshake.
// Optional BIN_TO_BCD_AUTO_TRIGGER_EN: self-start whenever bin differs from the last converted value.
module bin_to_bcd_serial
    import bin_to_bcd_serial_pkg::*;
#(
    parameter int unsigned bin_width = 8,
    parameter int unsigned digits    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [bin_width-1:0]  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*digits-1:0]   bcd
);

    localparam int unsigned BCD_W = 4 * digits;
    localparam int unsigned CNT_W = $clog2(bin_width + 1);

    state_t               state;
    state_t               state_n;
    logic [bin_width-1:0] shreg;
    logic [bin_width-1:0] shreg_n;
    logic [BCD_W-1:0]     scratch;
    logic [BCD_W-1:0]     scratch_n;
    logic [BCD_W-1:0]     adjusted;
    logic [BCD_W-1:0]     shifted;
    logic [BCD_W-1:0]     bcd_n;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_n;
    logic                 take;
    logic                 capture;

    bcd_add3_column #(.digits(digits)) u_add3 (
        .value    (scratch),
        .adjusted (adjusted)
    );

    // Corrected scratch shifted left with the next binary MSB entering bit 0.
    assign shifted = (adjusted << 1) | {{(BCD_W-1){1'b0}}, shreg[bin_width-1]};

`ifdef BIN_TO_BCD_AUTO_TRIGGER_EN
    logic [bin_width-1:0] last_bin;
    logic                 last_valid;
    logic                 auto_start_c;

    assign auto_start_c = ((state == ST_IDLE) || (state == ST_DONE)) &&
                          (!last_valid || (bin != last_bin));
    assign take = start | auto_start_c;

    // Invalid after reset so the first idle cycle converts whatever bin holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_bin   <= '1;
            last_valid <= 1'b0;
        end else if (capture) begin
            last_bin   <= bin;
            last_valid <= 1'b1;
        end
    end
`else
    assign take = start;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        scratch_n = scratch;
        cnt_n     = cnt;
        bcd_n     = bcd;
        capture   = 1'b0;

        case (state)
            ST_IDLE: begin
                capture = take;
            end
            ST_SHIFT: begin
                scratch_n = shifted;
                shreg_n   = shreg << 1;
                cnt_n     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    bcd_n   = shifted;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                capture = take;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (capture) begin
            shreg_n   = bin;
            scratch_n = '0;
            cnt_n     = CNT_W'(bin_width);
            state_n   = ST_SHIFT;
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            scratch <= scratch_n;
            cnt     <= cnt_n;
            bcd     <= bcd_n;
            busy    <= (state_n == ST_SHIFT);
            done    <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial: table vectors, corner sequences,
// and randomized traffic against a decimal-arithmetic reference model.
module tb_bin_to_bcd_serial;
    import bin_to_bcd_serial_pkg::*;

    localparam int unsigned BW   = 8;
    localparam int unsigned DG   = bcd_digits(BW);
    localparam int unsigned BW16 = 16;
    localparam int unsigned DG16 = 5;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [BW-1:0]     bin;
    logic              busy;
    logic              done;
    logic [4*DG-1:0]   bcd;
    logic              start16;
    logic [BW16-1:0]   bin16;
    logic              busy16;
    logic              done16;
    logic [4*DG16-1:0] bcd16;

    int vectors;
    int miscompares;

    // Reference model state.
    int          m_left;
    logic        m_done;
    logic [11:0] m_bcd;
    int unsigned m_val;

    typedef struct {
        logic [7:0]  b;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl [6];

    int   cyc;
    int   dn;
    int   last_done;
    logic seen;

    bin_to_bcd_serial #(.bin_width(BW), .digits(DG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    bin_to_bcd_serial #(.bin_width(BW16), .digits(DG16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .bin   (bin16),
        .busy  (busy16),
        .done  (done16),
        .bcd   (bcd16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] dec_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_done = 1'b0;
        m_bcd  = '0;
    endtask

    // Drive one cycle, advance the model on the edge, compare just after it.
    task automatic step(input logic s, input logic [7:0] b);
        start = s;
        bin   = b;
        @(posedge clk);
        if (m_left > 0) begin
            m_left = m_left - 1;
            m_done = (m_left == 0);
            if (m_done) m_bcd = 12'(dec_bcd(m_val));
        end else begin
            m_done = 1'b0;
            if (s) begin
                m_val  = 32'(b);
                m_left = BW;
            end
        end
        #1;
        check("busy", 32'(busy), 32'(m_left > 0));
        check("done", 32'(done), 32'(m_done));
        check("bcd",  32'(bcd),  32'(m_bcd));
    endtask

    // Bounded wait for a done pulse on the 8-bit instance.
    task automatic wait_done(input int limit, output logic got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(posedge clk);
            #1;
            if (done) got = 1'b1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        bin     = '0;
        start16 = 1'b0;
        bin16   = '0;
        model_reset();

        if (!(64'(10) ** DG > (64'd1 << BW) - 64'd1)) begin
            $display("FAIL digits_constraint: %0d digits cannot hold %0d bits", DG, BW);
            $fatal(1, "digit count too small");
        end

        tbl[0] = '{8'hFF,  12'h255};
        tbl[1] = '{8'd0,   12'h000};
        tbl[2] = '{8'd100, 12'h100};
        tbl[3] = '{8'd9,   12'h009};
        tbl[4] = '{8'd1,   12'h001};
        tbl[5] = '{8'd128, 12'h128};

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd",  32'(bcd),  32'd0);
        #3 rst_n = 1'b1;

`ifdef BIN_TO_BCD_AUTO_TRIGGER_EN
        // First idle cycle after reset converts the current bin unprompted.
        wait_done(30, seen);
        check("auto_first_done", 32'(seen), 32'd1);
        check("auto_first_bcd",  32'(bcd),  32'h000);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] v;
            v = (i == 0) ? 8'd77 : 8'($urandom);
            if (i == 0) v = 8'd77;
            @(negedge clk);
            bin = v;
            wait_done(30, seen);
            check("auto_done", 32'(seen), 32'd1);
            check("auto_bcd",  32'(bcd),  32'(12'(dec_bcd(32'(v)))));
        end
        repeat (12) @(posedge clk);
        #1;
        check("auto_quiet_busy", 32'(busy), 32'd0);
`else
        // Wide instance: 16 bits into 5 digits.
        for (int i = 0; i < 2; i++) begin
            start16 = 1'b1;
            bin16   = (i == 0) ? 16'hFFFF : 16'd10000;
            @(posedge clk);
            #1;
            start16 = 1'b0;
            cyc = 0;
            while (!done16 && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("w16_latency", 32'(cyc), 32'd16);
            check("w16_bcd", 32'(bcd16), (i == 0) ? 32'h65535 : 32'h10000);
            @(posedge clk);
            #1;
        end

        // Table vectors; bin scrambled while busy must not matter.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tbl[i].b);
            for (int c = 0; c < 7; c++) step(1'b0, 8'($urandom));
            step(1'b0, 8'($urandom));
            check("tbl_done", 32'(done), 32'd1);
            check("tbl_bcd",  32'(bcd),  32'(tbl[i].exp));
            step(1'b0, 8'($urandom));
            check("tbl_hold", 32'(bcd),  32'(tbl[i].exp));
        end

        // A second start three cycles into a conversion is ignored.
        dn = 0;
        step(1'b1, 8'd200);
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        step(1'b1, 8'd42);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 8'd42);
            if (done) dn++;
        end
        check("ignored_done_count", 32'(dn), 32'd1);
        check("ignored_bcd", 32'(bcd), 32'h200);

        // Reset mid-shift clears outputs at once; no done afterwards.
        step(1'b1, 8'd123);
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_bcd",  32'(bcd),  32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) step(1'b0, 8'($urandom));

        // start held high with bin stepping: a done every 9 cycles.
        last_done = -1;
        for (int n = 0; n < 256; n++) begin
            step(1'b1, 8'(n));
            if (done) begin
                if (last_done >= 0) check("done_period", 32'(n - last_done), 32'd9);
                last_done = n;
            end
        end
        step(1'b0, 8'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom));
        end
        for (int n = 0; n < 10; n++) step(1'b0, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_serial.md
Name: bin_to_bcd_serial

Overview:
- Sequential double-dabble binary-to-BCD converter.
- Sits between the ultrasonic receiver's relative_distance output and the per-digit 7-segment display drivers, so the distance shows in decimal, not hex.
- Converts one bit per clock, using one add-3 column per digit.
- Uses a start/busy/done handshake and a registered, held BCD output.

Parameters:
- bin_width, 8: width of the binary input.
- digits, 3: number of BCD output digits. Must satisfy 10^digits > 2^bin_width - 1; the bench checks this at elaboration.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion of bin. Sampled on the rising edge.
- bin  input  bin_width  binary value. Captured only on the edge where start is accepted.
- busy  output  1  high while shifting. start is ignored while busy is high.
- done  output  1  one-cycle pulse when bcd has been updated.
- bcd  output  4*digits  packed BCD, digit 0 in [3:0]. Registered and held between conversions.

Behaviour:
- Reset (async, rst_n low): state IDLE, busy=0, done=0, bcd=0, shift register and bit counter cleared. Asserting reset mid-conversion aborts the conversion immediately; no done is produced.
- States:
  - IDLE: waiting for start.
  - SHIFT: bin_width iterations.
  - DONE: one cycle.
- Start acceptance:
  - start is accepted in IDLE or DONE, so back-to-back conversions are allowed.
  - On acceptance: capture bin into the binary shift register, clear the BCD scratch register, load the counter with bin_width, go to SHIFT.
  - start in SHIFT is ignored and not queued.
- SHIFT iteration (each cycle):
  - Every scratch digit >= 5 gets +3 (4-bit add, no carry between digits).
  - Then {scratch, binary} shifts left by 1, MSB of binary entering scratch bit 0.
  - Counter decrements.
  - When the counter hits 1, the same edge also loads bcd from the final scratch value and moves to DONE.
- DONE: done=1 for this single cycle. Next state is IDLE, or SHIFT if start is high (new capture).
- Latency: done is high in the cycle after the bin_width-th rising edge following the edge that accepted start. For the default, start sampled at edge k gives done high during cycle k+8. bcd changes on that same edge.
- busy = (state == SHIFT). busy and done are never high together.
- Outputs are registered, or a direct decode of the registered state.
- bcd never shows intermediate scratch values. It changes only on the edge entering DONE.
- bin changing while busy has no effect.
- Arithmetic: the scratch register is 4*digits bits wide; add-3 is applied per nibble; no overflow given the digits constraint.

Optional Feature:
- Macro BIN_TO_BCD_AUTO_TRIGGER_EN.
- When defined:
  - An internal register holds the last converted bin.
  - An internal start is generated whenever state is IDLE/DONE and bin differs from that register.
  - The register is updated on capture.
  - This internal start is ORed with the start port.
  - After reset, the held value is all-ones-plus-invalid flag, so the first idle cycle triggers a conversion.
  - The board can then tie start to 0 and still track the receiver continuously.
- When undefined: conversions happen only on explicit start. No extra registers.

Decomposition:
- Shared include/package holds the state encoding localparams (IDLE, SHIFT, DONE) and a digits-from-width helper function used by top-level instantiations.
- One natural sub-module: bcd_add3_column. It is combinational, takes 4*digits in and gives 4*digits out, and applies per-nibble add-3-if->=5. It is instantiated once inside the SHIFT datapath.

Test Plan:
- bin=8'hFF, one-cycle start at edge k -> busy high cycles k+1..k+8, done high only in cycle k+8, bcd=12'h255, held afterwards.
- bin=0 -> bcd=12'h000, done after 8 cycles. Then bin=8'd100 -> 12'h100. Then bin=8'd9 -> 12'h009.
- start and bin=8'd42 pulsed again 3 cycles after the first start (bin=200) -> ignored; bcd=12'h200, exactly one done.
- rst_n low for 1 cycle mid-SHIFT -> busy, done, bcd all 0 immediately; no done until a new start.
- start held high continuously with bin stepping 0..255 -> a done every 9 cycles; each bcd matches the decimal value of bin captured at the corresponding acceptance.
- bin_width=16, digits=5, bin=65535 -> bcd=20'h65535 after 16 cycles. With BIN_TO_BCD_AUTO_TRIGGER_EN defined and start=0, changing bin to 8'd77 -> conversion starts unprompted and bcd=12'h077.
